// File: rtl/upc_loop_status_monitor.sv
// Passive status monitor for one ap_ctrl-style HLS block and its single pipelined loop.
// Tracks module transactions/latency, loop activations, iteration counts and initiation interval.
module upc_loop_status_monitor #(
    parameter int STATE_W = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    output logic               mod_busy,
    output logic [CNT_W-1:0]   mod_txn_cnt,
    output logic [CNT_W-1:0]   mod_last_lat,
    output logic [CNT_W-1:0]   mod_max_lat,
    output logic               loop_active,
    output logic [CNT_W-1:0]   iter_start_cnt,
    output logic [CNT_W-1:0]   iter_end_cnt,
    output logic [CNT_W-1:0]   iter_inflight,
    output logic [CNT_W-1:0]   loop_quit_cnt,
    output logic [CNT_W-1:0]   last_ii,
    output logic [CNT_W-1:0]   min_ii,
    output logic               frozen
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [CNT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_gap;
    logic             r_have_is;

    logic             w_s, w_d, w_is, w_ie, w_q, w_ls, w_ld, w_quit, w_ii_upd;
    logic [CNT_W-1:0] w_lat_now;
    logic [CNT_W-1:0] w_start_nxt, w_end_nxt, w_inflight_nxt;
    logic             w_unused;

    // ap_ready and loop_ready are status-only taps; no statistic depends on them
    assign w_unused = ap_ready ^ loop_ready;

    assign w_s  = ap_start & ~mod_busy;
    assign w_d  = ap_done & ap_continue;
    assign w_is = (cur_state == iter_start_state) & ~iter_start_block & iter_start_enable;
    assign w_ie = (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable;
    assign w_q  = (cur_state == quit_state) & ~quit_block & quit_enable;
    assign w_ls = loop_start & ~loop_active;
    assign w_ld = loop_done & loop_continue;

    assign w_quit    = loop_active & (quit_at_end ? (w_q & w_ie) : w_ld);
    assign w_lat_now = mod_busy ? sat_inc(r_lat) : CNT_ONE;

    assign w_start_nxt    = w_is ? sat_inc(iter_start_cnt) : iter_start_cnt;
    assign w_end_nxt      = w_ie ? sat_inc(iter_end_cnt) : iter_end_cnt;
    assign w_inflight_nxt = (w_start_nxt >= w_end_nxt) ? (w_start_nxt - w_end_nxt) : '0;

    // The first IS of an activation only arms the gap counter; II is taken from the second on
    assign w_ii_upd = w_is & r_have_is & ~w_ls;

    always_ff @(posedge clock) begin
        if (reset) begin
            mod_busy       <= 1'b0;
            mod_txn_cnt    <= '0;
            mod_last_lat   <= '0;
            mod_max_lat    <= '0;
            loop_active    <= 1'b0;
            iter_start_cnt <= '0;
            iter_end_cnt   <= '0;
            iter_inflight  <= '0;
            loop_quit_cnt  <= '0;
            last_ii        <= '0;
            min_ii         <= CNT_MAX;
            frozen         <= 1'b0;
            r_lat          <= '0;
            r_gap          <= '0;
            r_have_is      <= 1'b0;
        end else if (!frozen) begin
            frozen <= finish;

            if (w_s || mod_busy) begin
                r_lat <= w_lat_now;
            end
            if (w_d) begin
                mod_txn_cnt  <= sat_inc(mod_txn_cnt);
                mod_last_lat <= w_lat_now;
                if (w_lat_now > mod_max_lat) begin
                    mod_max_lat <= w_lat_now;
                end
            end
            mod_busy <= (w_s | mod_busy) & ~w_d;

            loop_active <= w_ls | (loop_active & ~w_quit);
            if (w_quit) begin
                loop_quit_cnt <= sat_inc(loop_quit_cnt);
            end

            iter_start_cnt <= w_start_nxt;
            iter_end_cnt   <= w_end_nxt;
            iter_inflight  <= w_inflight_nxt;

            r_gap <= w_is ? CNT_ONE : sat_inc(r_gap);
            if (w_ii_upd) begin
                last_ii <= r_gap;
                if (r_gap < min_ii) begin
                    min_ii <= r_gap;
                end
            end
            if (w_ls) begin
                r_have_is <= w_is;
            end else if (w_is) begin
                r_have_is <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_upc_loop_status_monitor.sv
// Scoreboard bench for upc_loop_status_monitor: a cycle-stamp reference model queues the
// expected status after each edge; an independent monitor pops and compares every cycle.
module tb_upc_loop_status_monitor;

    localparam int     STATE_W = 2;
    localparam int     CNT_W   = 8;
    localparam longint MAXV    = (longint'(1) << CNT_W) - 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset, finish, ap_start, ap_ready, ap_done, ap_continue;
    logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic               iter_start_block, iter_end_block, quit_block;
    logic               iter_start_enable, iter_end_enable, quit_enable;
    logic               loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
    logic               mod_busy, loop_active, frozen;
    logic [CNT_W-1:0]   mod_txn_cnt, mod_last_lat, mod_max_lat, iter_start_cnt, iter_end_cnt;
    logic [CNT_W-1:0]   iter_inflight, loop_quit_cnt, last_ii, min_ii;

    upc_loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
        .quit_block(quit_block), .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .mod_busy(mod_busy), .mod_txn_cnt(mod_txn_cnt), .mod_last_lat(mod_last_lat),
        .mod_max_lat(mod_max_lat), .loop_active(loop_active),
        .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
        .iter_inflight(iter_inflight), .loop_quit_cnt(loop_quit_cnt),
        .last_ii(last_ii), .min_ii(min_ii), .frozen(frozen)
    );

    typedef struct {
        bit     busy, act, frz;
        longint txn, lastl, maxl, st, en, inf, qc, lii, mii;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: latencies and gaps come from cycle-stamp differences, clipped at MAXV
    bit     m_busy, m_act, m_frz, m_have;
    longint m_txn, m_lastl, m_maxl, m_st, m_en, m_qc, m_lii, m_mii;
    longint m_start_cyc, m_last_is_cyc, cyc = 0;

    function automatic longint sat(input longint v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic model_step();
        bit s, d, is_e, ie_e, q_e, ls, ld, quit;
        longint lat, gap;
        if (reset) begin
            m_busy = 0; m_act = 0; m_frz = 0; m_have = 0;
            m_txn = 0; m_lastl = 0; m_maxl = 0; m_st = 0; m_en = 0; m_qc = 0;
            m_lii = 0; m_mii = MAXV;
        end else if (!m_frz) begin
            s    = ap_start && !m_busy;
            d    = ap_done && ap_continue;
            is_e = (cur_state == iter_start_state) && !iter_start_block && iter_start_enable;
            ie_e = (cur_state == iter_end_state) && !iter_end_block && iter_end_enable;
            q_e  = (cur_state == quit_state) && !quit_block && quit_enable;
            ls   = loop_start && !m_act;
            ld   = loop_done && loop_continue;
            if (s) m_start_cyc = cyc;
            if (d) begin
                lat = (m_busy || s) ? sat(cyc - m_start_cyc + 1) : 1;
                m_txn = sat(m_txn + 1);
                m_lastl = lat;
                if (lat > m_maxl) m_maxl = lat;
            end
            m_busy = (s || m_busy) && !d;
            quit = m_act && (quit_at_end ? (q_e && ie_e) : ld);
            if (quit) m_qc = sat(m_qc + 1);
            m_act = ls ? 1'b1 : (quit ? 1'b0 : m_act);
            if (is_e) m_st = sat(m_st + 1);
            if (ie_e) m_en = sat(m_en + 1);
            if (is_e) begin
                if (m_have && !ls) begin
                    gap = sat(cyc - m_last_is_cyc);
                    m_lii = gap;
                    if (gap < m_mii) m_mii = gap;
                end
                m_last_is_cyc = cyc;
            end
            m_have = ls ? is_e : (m_have || is_e);
            if (finish) m_frz = 1;
        end
        cyc++;
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.busy = m_busy; e.act = m_act; e.frz = m_frz;
        e.txn = m_txn; e.lastl = m_lastl; e.maxl = m_maxl; e.st = m_st; e.en = m_en;
        e.inf = (m_st >= m_en) ? (m_st - m_en) : 0;
        e.qc = m_qc; e.lii = m_lii; e.mii = m_mii;
        q.push_back(e);
        @(negedge clock);
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic idle();
        reset = 0; finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
        cur_state = 0; iter_start_state = 0; iter_end_state = 0; quit_state = 0;
        iter_start_block = 0; iter_end_block = 0; quit_block = 0;
        iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
    endtask

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mod_busy", longint'(mod_busy), longint'(e.busy));
                chk("mod_txn_cnt", longint'(mod_txn_cnt), e.txn);
                chk("mod_last_lat", longint'(mod_last_lat), e.lastl);
                chk("mod_max_lat", longint'(mod_max_lat), e.maxl);
                chk("loop_active", longint'(loop_active), longint'(e.act));
                chk("iter_start_cnt", longint'(iter_start_cnt), e.st);
                chk("iter_end_cnt", longint'(iter_end_cnt), e.en);
                chk("iter_inflight", longint'(iter_inflight), e.inf);
                chk("loop_quit_cnt", longint'(loop_quit_cnt), e.qc);
                chk("last_ii", longint'(last_ii), e.lii);
                chk("min_ii", longint'(min_ii), e.mii);
                chk("frozen", longint'(frozen), longint'(e.frz));
            end
        end
    end

    initial begin : stimulus
        idle();
        reset = 1;
        cycles(2);
        reset = 0;
        cycles(2);

        // module latency: S at cycle 0, D at cycle 9
        ap_start = 1; tick(); ap_start = 0;
        cycles(8);
        ap_done = 1; ap_continue = 1; tick(); idle();
        cycles(2);

        // full pipeline: 100 back-to-back IS, IE from 141 cycles later, then LD
        loop_start = 1; tick(); loop_start = 0;
        for (int i = 0; i < 241; i++) begin
            iter_start_enable = (i < 100);
            iter_end_enable   = (i >= 141);
            tick();
        end
        idle();
        loop_done = 1; loop_continue = 1; tick(); idle();
        cycles(2);

        // stall of 3 cycles between two IS
        loop_start = 1; tick(); idle();
        iter_start_enable = 1; tick();
        iter_start_block = 1; cycles(3);
        iter_start_block = 0; tick();
        idle(); tick();

        // same-cycle events and a D with no open transaction
        ap_start = 1; ap_done = 1; ap_continue = 1; tick(); idle();
        ap_done = 1; ap_continue = 1; tick(); idle();
        iter_start_enable = 1; tick();
        iter_end_enable = 1; tick();
        idle(); iter_end_enable = 1; tick(); idle();
        tick();

        // quit coinciding with last iteration end; LD alone must not quit here
        quit_at_end = 1; loop_done = 1; loop_continue = 1; tick();
        loop_done = 0; loop_continue = 0; quit_enable = 1; iter_end_enable = 1; tick();
        idle(); tick();

        // saturation of iteration starts and of latency
        reset = 1; tick(); reset = 0;
        iter_start_enable = 1; cycles(300); idle();
        ap_start = 1; tick(); ap_start = 0;
        cycles(300);
        ap_done = 1; ap_continue = 1; tick(); idle();
        tick();

        // finish: events in the finish cycle count, later ones do not
        reset = 1; tick(); reset = 0;
        ap_start = 1; iter_start_enable = 1; finish = 1; tick();
        finish = 0; ap_start = 0; ap_done = 1; ap_continue = 1; loop_start = 1;
        cycles(5); idle();
        reset = 1; tick(); reset = 0;
        tick();

        // randomized traffic with occasional reset and finish
        for (int i = 0; i < 3000; i++) begin
            reset             = ($urandom_range(249) == 0);
            finish            = ($urandom_range(399) == 0);
            ap_start          = ($urandom_range(9) < 3);
            ap_ready          = $urandom_range(1);
            ap_done           = ($urandom_range(9) < 2);
            ap_continue       = ($urandom_range(9) < 7);
            cur_state         = STATE_W'($urandom_range(3));
            iter_start_state  = STATE_W'($urandom_range(1));
            iter_end_state    = STATE_W'($urandom_range(1));
            quit_state        = STATE_W'($urandom_range(1));
            iter_start_block  = ($urandom_range(9) == 0);
            iter_end_block    = ($urandom_range(9) == 0);
            quit_block        = ($urandom_range(9) == 0);
            iter_start_enable = ($urandom_range(9) < 7);
            iter_end_enable   = ($urandom_range(9) < 6);
            quit_enable       = ($urandom_range(9) < 5);
            loop_start        = ($urandom_range(9) < 2);
            loop_ready        = $urandom_range(1);
            loop_done         = ($urandom_range(19) == 0);
            loop_continue     = ($urandom_range(9) < 8);
            quit_at_end       = ($urandom_range(3) == 0);
            tick();
        end
        idle();
        cycles(2);

        @(posedge clock);
        #2;
        chk("scoreboard_drain", longint'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
